// File: rtl/lsu_pkg.sv
// Shared width codes, state encoding and request payload for the load/store unit.
package lsu_pkg;

   localparam int unsigned LANE_BYTES = 4;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} lsu_state_e;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_e;

   typedef struct packed {
      logic        we;
      logic [2:0]  funct3;
      logic [1:0]  offset;
      logic [31:0] wdata;
   } lsu_req_t;

   // Reserved width codes fall through to a full word.
   function automatic lsu_size_e lsu_size(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: return SZ_B;
         F3_H, F3_HU: return SZ_H;
         F3_W:        return SZ_W;
         default:     return SZ_W;
      endcase
   endfunction

   function automatic logic lsu_misaligned(input lsu_size_e sz, input logic [1:0] off);
      return (sz == SZ_H && off[0]) || (sz == SZ_W && off != 2'b00);
   endfunction

endpackage

// File: rtl/lsu_lane.sv
// Byte-lane steering: load extract with sign/zero extension, and sub-word store merge.
module lsu_lane
   import lsu_pkg::*;
(
   input  logic [2:0]              funct3_i,
   input  logic [1:0]              offset_i,
   input  logic [8*LANE_BYTES-1:0] rdata_i,
   input  logic [8*LANE_BYTES-1:0] wdata_i,
   output logic [8*LANE_BYTES-1:0] ld_data_c_o,
   output logic [8*LANE_BYTES-1:0] st_data_c_o
);

   lsu_size_e  sz;
   logic       sext;
   logic [7:0] byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      sz          = lsu_size(funct3_i);
      sext        = ~funct3_i[2];
      half_sel    = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      byte_sel    = offset_i[0] ? half_sel[15:8] : half_sel[7:0];
      ld_data_c_o = rdata_i;
      st_data_c_o = wdata_i;
      case (sz)
         SZ_B: begin
            ld_data_c_o = {{24{sext & byte_sel[7]}}, byte_sel};
            st_data_c_o = rdata_i;
            st_data_c_o[{offset_i, 3'b000} +: 8] = wdata_i[7:0];
         end
         SZ_H: begin
            ld_data_c_o = {{16{sext & half_sel[15]}}, half_sel};
            st_data_c_o = rdata_i;
            st_data_c_o[{offset_i[1], 4'b0000} +: 16] = wdata_i[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: sequences core accesses onto a single-port word memory, using
// read-modify-write for sub-word stores. Define LSU_ALIGN_CHECK_EN to flag misaligned accesses.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_op,
   output logic                  mem_rw,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_data_w,
   input  logic [DATA_WIDTH-1:0] mem_data_r
);

   lsu_state_e            state_q;
   lsu_req_t              req_q;
   lsu_size_e             acc_size_c;
   logic                  acc_err_c;
   logic [1:0]            acc_off_c;
   logic [DATA_WIDTH-1:0] ld_data_c;
   logic [DATA_WIDTH-1:0] st_data_c;

   // Decode the incoming request: either flag misalignment or force natural alignment.
   always_comb begin
      acc_size_c = lsu_size(req_funct3);
      acc_err_c  = 1'b0;
      acc_off_c  = req_addr[1:0];
`ifdef LSU_ALIGN_CHECK_EN
      acc_err_c  = lsu_misaligned(acc_size_c, req_addr[1:0]);
`else
      case (acc_size_c)
         SZ_H:    acc_off_c = {req_addr[1], 1'b0};
         SZ_W:    acc_off_c = 2'b00;
         default: ;
      endcase
`endif
   end

   lsu_lane u_lane (
      .funct3_i    (req_q.funct3),
      .offset_i    (req_q.offset),
      .rdata_i     (mem_data_r),
      .wdata_i     (req_q.wdata),
      .ld_data_c_o (ld_data_c),
      .st_data_c_o (st_data_c)
   );

   // Sequencer; every output is set on the transition into the state that owns it.
   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q    <= IDLE;
         req_q      <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_op     <= 1'b0;
         mem_rw     <= 1'b0;
         mem_addr   <= '0;
         mem_data_w <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_q     <= '{we: req_we, funct3: req_funct3, offset: acc_off_c, wdata: req_wdata};
                  mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                  req_ready <= 1'b0;
                  if (acc_err_c) begin
                     state_q    <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else if (req_we && acc_size_c == SZ_W) begin
                     state_q    <= WR;
                     mem_op     <= 1'b1;
                     mem_rw     <= 1'b1;
                     mem_data_w <= req_wdata;
                  end else begin
                     state_q <= RD;
                     mem_op  <= 1'b1;
                     mem_rw  <= 1'b0;
                  end
               end
            end
            RD: begin
               state_q <= CAP;
               mem_op  <= 1'b0;
            end
            CAP: begin
               if (req_q.we) begin
                  state_q    <= WR;
                  mem_op     <= 1'b1;
                  mem_rw     <= 1'b1;
                  mem_data_w <= st_data_c;
               end else begin
                  state_q    <= RESP;
                  resp_rdata <= ld_data_c;
                  resp_valid <= 1'b1;
               end
            end
            WR: begin
               state_q    <= RESP;
               mem_op     <= 1'b0;
               resp_valid <= 1'b1;
            end
            RESP: begin
               state_q    <= IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               req_ready  <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors plus random accesses against a word-array model.
module tb_load_store_unit;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_op;
   logic        mem_rw;
   logic [31:0] mem_addr;
   logic [31:0] mem_data_w;
   logic [31:0] mem_data_r = '0;

   int n_checks = 0;
   int n_errors = 0;
   int n_rd = 0;
   int n_wr = 0;
   int n_bad_addr = 0;

   logic [31:0] mem [16] = '{default: 32'h0};
   logic [31:0] ref_mem [16] = '{default: 32'h0};
   logic [31:0] last_rdata = '0;

   always #5 sys_clk = ~sys_clk;

   load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .sys_clk    (sys_clk),
      .sys_rst    (sys_rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_op     (mem_op),
      .mem_rw     (mem_rw),
      .mem_addr   (mem_addr),
      .mem_data_w (mem_data_w),
      .mem_data_r (mem_data_r)
   );

   // Memory: read data appears the cycle after the read command.
   always @(posedge sys_clk) begin
      if (mem_op) begin
         if (mem_addr[1:0] != 2'b00 || mem_addr[31:6] != '0) n_bad_addr++;
         if (mem_rw) begin
            mem[mem_addr[5:2]] = mem_data_w;
            n_wr++;
         end else begin
            mem_data_r <= mem[mem_addr[5:2]];
            n_rd++;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input string pfx);
      chk({pfx, "_ready"},   32'(req_ready),  32'd1);
      chk({pfx, "_rvalid"},  32'(resp_valid), 32'd0);
      chk({pfx, "_rdata"},   resp_rdata,      32'd0);
      chk({pfx, "_err"},     32'(resp_err),   32'd0);
      chk({pfx, "_memop"},   32'(mem_op),     32'd0);
      chk({pfx, "_memrw"},   32'(mem_rw),     32'd0);
      chk({pfx, "_memaddr"}, mem_addr,        32'd0);
      chk({pfx, "_memdw"},   mem_data_w,      32'd0);
   endtask

   // One access: model the expected outcome, drive it, then compare latency, data and memory traffic.
   task automatic do_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wdata, input bit hold);
      int sz, off, idx, exp_lat, exp_rd, exp_wr, lat, rd0, wr0;
      bit err;
      logic [31:0] eff, mask, word, val, exp_rdata;
      sz   = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      mask = (sz == 1) ? 32'hFF : (sz == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
      err  = 1'b0;
      eff  = addr;
`ifdef LSU_ALIGN_CHECK_EN
      err  = (sz == 2 && addr[0]) || (sz == 4 && addr[1:0] != 2'b00);
`else
      eff  = addr & ~32'(sz - 1);
`endif
      idx  = int'(eff >> 2);
      off  = int'(eff & 32'd3);
      word = ref_mem[idx];
      exp_rdata = last_rdata;
      if (err) begin
         exp_lat = 1; exp_rd = 0; exp_wr = 0;
      end else if (!we) begin
         exp_lat = 3; exp_rd = 1; exp_wr = 0;
         val = (word >> (8 * off)) & mask;
         if (f3 < 3'd4 && sz < 4 && val[8*sz-1]) val = val | ~mask;
         exp_rdata = val;
      end else if (sz == 4) begin
         exp_lat = 2; exp_rd = 0; exp_wr = 1;
         ref_mem[idx] = wdata;
      end else begin
         exp_lat = 4; exp_rd = 1; exp_wr = 1;
         ref_mem[idx] = (word & ~(mask << (8 * off))) | ((wdata & mask) << (8 * off));
      end

      rd0 = n_rd;
      wr0 = n_wr;
      @(negedge sys_clk);
      chk("ready_idle", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge sys_clk);
      #1;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      if (!hold) req_valid = 1'b0;

      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge sys_clk);
         if (resp_valid) begin
            lat = k;
            break;
         end
      end
      chk("latency", 32'(lat), 32'(exp_lat));
      if (lat != 0) begin
         chk("resp_err", 32'(resp_err), 32'(err));
         chk("resp_rdata", resp_rdata, exp_rdata);
      end
      req_valid = 1'b0;
      @(negedge sys_clk);
      chk("resp_pulse", 32'(resp_valid), 32'd0);
      chk("ready_back", 32'(req_ready), 32'd1);
      chk("mem_reads", 32'(n_rd - rd0), 32'(exp_rd));
      chk("mem_writes", 32'(n_wr - wr0), 32'(exp_wr));
      if (we && !err) chk("mem_word", mem[idx], ref_mem[idx]);
      last_rdata = exp_rdata;
   endtask

   initial begin
      int wr0;
      repeat (2) @(negedge sys_clk);
      chk_reset("reset");
      sys_rst = 1'b1;

      // Word load from a preloaded location.
      do_access(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
      do_access(1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
      chk("lw_deadbeef", resp_rdata, 32'hDEADBEEF);

      // Signed and unsigned byte loads of a negative byte.
      do_access(1'b1, 3'b010, 32'h10, 32'h80112233, 1'b0);
      do_access(1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
      chk("lb_sext", resp_rdata, 32'hFFFFFF80);
      do_access(1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
      chk("lbu_zext", resp_rdata, 32'h00000080);

      // Byte store merges into the existing word.
      do_access(1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0);
      do_access(1'b1, 3'b000, 32'h21, 32'h555555AA, 1'b0);
      chk("sb_merge", mem[8], 32'h1122AA44);
      do_access(1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
      chk("lw_after_sb", resp_rdata, 32'h1122AA44);

      // Word store with req_valid held through the busy period.
      do_access(1'b1, 3'b010, 32'h08, 32'hCAFEF00D, 1'b1);
      chk("sw_word", mem[2], 32'hCAFEF00D);

      // Half load at an odd address.
      do_access(1'b1, 3'b010, 32'h04, 32'h12348765, 1'b0);
      do_access(1'b0, 3'b001, 32'h05, 32'h0, 1'b0);
`ifdef LSU_ALIGN_CHECK_EN
      chk("lh_misaligned_err", 32'(resp_err), 32'd0);
`else
      chk("lh_forced_align", resp_rdata, 32'hFFFF8765);
`endif

      // Reset during the CAP cycle of a half store must drop the pending write.
      wr0 = n_wr;
      @(negedge sys_clk);
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'b001;
      req_addr   = 32'h2A;
      req_wdata  = 32'h0000BEEF;
      @(posedge sys_clk);
      #1;
      req_valid = 1'b0;
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      #1;
      chk_reset("abort");
      repeat (2) @(negedge sys_clk);
      chk("abort_no_write", 32'(n_wr - wr0), 32'd0);
      chk("abort_mem", mem[10], ref_mem[10]);
      sys_rst    = 1'b1;
      last_rdata = '0;
      do_access(1'b0, 3'b010, 32'h28, 32'h0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         do_access(1'($urandom), 3'($urandom), 32'($urandom_range(0, 63)), $urandom, 1'($urandom));
      end

      chk("mem_addr_aligned", 32'(n_bad_addr), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL take parameter ADDR_WIDTH, default 32, as the byte address width.
REQ-002 The block SHALL take parameter DATA_WIDTH, default 32, as the memory word width; only 32 is supported.
REQ-003 The block SHALL have port sys_clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port sys_rst, input, 1 bit: asynchronous reset, active-low.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the core presents an access.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept an access.
REQ-007 The block SHALL have port req_we, input, 1 bit: 0 = load, 1 = store.
REQ-008 The block SHALL have port req_funct3, input, 3 bits: RISC-V width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-009 The block SHALL have port req_addr, input, ADDR_WIDTH bits: the byte address.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: store data, LSB-aligned.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: a one-cycle completion pulse.
REQ-012 The block SHALL have port resp_rdata, output, 32 bits: load result, sign- or zero-extended.
REQ-013 The block SHALL have port resp_err, output, 1 bit: the access was misaligned.
REQ-014 The block SHALL have ports mem_op (out, 1), mem_rw (out, 1; 0 = read, 1 = write), mem_addr (out, ADDR_WIDTH), mem_data_w (out, 32) and mem_data_r (in, 32), which drive the memory controller.

Function
REQ-015 The block SHALL use states IDLE, RD, CAP, WR and RESP.
REQ-016 The block SHALL assert req_ready only in IDLE; an access is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-017 The block SHALL register req_we, req_funct3, req_addr and req_wdata on acceptance; later changes to req_* have no effect.
REQ-018 The block SHALL always drive mem_addr as the captured address with bits [1:0] = 00.
REQ-019 In RD, the block SHALL drive mem_op=1 and mem_rw=0 for exactly one cycle.
REQ-020 The block SHALL treat mem_data_r as valid in the cycle after RD, which is CAP.
REQ-021 In WR, the block SHALL drive mem_op=1, mem_rw=1 and mem_data_w for exactly one cycle.
REQ-022 In every other state, the block SHALL hold mem_op at 0.
REQ-023 Load transitions SHALL be IDLE, RD, CAP, RESP, IDLE; resp_valid rises 3 cycles after acceptance.
REQ-024 Word store transitions SHALL be IDLE, WR, RESP, IDLE; mem_data_w = wdata.
REQ-025 Byte or half store transitions SHALL be IDLE, RD, CAP, WR, RESP, IDLE (read-modify-write).
REQ-026 For a byte or half store, mem_data_w SHALL be the CAP word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
REQ-027 For loads, the block SHALL select the lane from addr[1:0]; B and H are sign-extended, BU and HU are zero-extended, W is passed through.
REQ-028 The block SHALL register resp_rdata in CAP and hold it until the next load's CAP.
REQ-029 After a store, resp_rdata SHALL be unchanged.
REQ-030 The block SHALL assert resp_valid for exactly one cycle, in RESP.
REQ-031 The block SHALL treat funct3 011, 110 and 111 as W.
REQ-032 The block SHALL treat H with addr[0]=1 and W with addr[1:0]!=00 as misaligned (see REQ-036).
REQ-033 The block SHALL ignore req_valid=1 during a busy state; no request is queued.

Reset
REQ-034 While sys_rst=0, the block SHALL set state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_op=0, mem_rw=0, mem_addr=0 and mem_data_w=0.
REQ-035 Reset asserted mid-access SHALL abandon the access immediately; a pending RMW write is never issued.

Configuration
REQ-036 With LSU_ALIGN_CHECK_EN defined, a misaligned access SHALL go IDLE, RESP with resp_err=1, no mem_op and resp_rdata unchanged; without it, resp_err SHALL be tied 0 and low address bits SHALL be forced to natural alignment (H clears bit 0, W clears bits 1:0).

Structure
REQ-037 Package lsu_pkg SHALL hold the funct3 width-code constants, the state enum typedef and the LANE_BYTES constant.
REQ-038 Sub-module lsu_lane (combinational load extract/extend and store merge) SHALL be instantiated once.

Verification
REQ-039 Reset, then LW at 0x10 with word 0xDEADBEEF in memory -> resp_valid at cycle 3, rdata=0xDEADBEEF, resp_err=0.
REQ-040 LB at 0x13 with word 0x80112233 -> rdata=0xFFFFFF80; LBU at 0x13 -> 0x00000080.
REQ-041 SB wdata=0xAA at 0x21 over word 0x11223344 -> exactly one read and one write, mem_data_w=0x1122AA44, then LW at 0x20 returns 0x1122AA44.
REQ-042 SW 0xCAFEF00D at 0x08 -> no read cycle, resp at cycle 2.
REQ-042 (cont.) req_valid held high during busy -> exactly one access performed.
REQ-043 LH at 0x05 with LSU_ALIGN_CHECK_EN defined -> resp_err=1 at cycle 1, mem_op never 1; without the macro -> reads 0x04 and returns the sign-extended lane at 0x04.
REQ-044 Assert sys_rst=0 during CAP of an SH -> mem_op stays 0 and all outputs are at reset values; the next access completes normally.
